tournament_chooser: RTL and testbench
=====================================

# tournament_chooser

Parametrised tournament chooser between the pshare and gshare predictors, one per fetch stream. Selects each cycle's direction and next PC from a per-PC saturating chooser table. Holds up to DEPTH unresolved predictions in an in-order queue, so outcomes that arrive several cycles later train the entry that actually made the choice. Adds table auto-initialisation, a flush path, and saturating hit/miss statistics.

## Interface
- N, 32: PC and target width.
- IDX_BITS, 10: chooser index width; table holds 2^IDX_BITS entries.
- CTR_BITS, 2: chooser counter width (≥2).
- DEPTH, 4: maximum in-flight (unresolved) predictions; power of two.
- STAT_BITS, 32: hit/miss counter width.

- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- predict_valid  in  1  a branch is being predicted this cycle.
- pred_ready  out  1  a prediction may be accepted this cycle.
- PC  in  N  branch PC.
- prediction_ph, prediction_gh  in  1 each  pshare and gshare directions.
- ph_PC, gh_PC  in  N each  pshare and gshare next-PC.
- prediction  out  1  chosen direction.
- nex_PC  out  N  chosen next PC.
- choice_gh  out  1  1 means the gshare path was chosen.
- resolve_valid  in  1  the oldest in-flight branch resolves this cycle.
- fix_result  in  1  actual outcome of that branch.
- flush  in  1  squash all in-flight entries.
- inflight  out  log2(DEPTH)+1  queue occupancy.
- hit, miss  out  STAT_BITS each  resolved-correct and resolved-wrong counts.
- resolve_err  out  1  sticky; set by a resolve while the queue is empty.

## Operation
- Index = PC[IDX_BITS+1:2].
- Counter MSB=0 selects pshare (prediction_ph, ph_PC). MSB=1 selects gshare.
- prediction, nex_PC and choice_gh are combinational from the current table contents and inputs; they are valid whenever predict_valid is high.
- FSM states:
  - INIT: after reset, write 2^(CTR_BITS-1)-1 (weak pshare; 01 for 2-bit) into entries 0..2^IDX_BITS-1, one per cycle. pred_ready=0. Outputs force the pshare path.
  - RUN: entered after the last entry is written.
- Accept = predict_valid & pred_ready. On accept, push {index, prediction_ph, prediction_gh, prediction} to the queue tail.
- pred_ready = RUN & !flush & (inflight<DEPTH | resolve_valid). A push and a pop in the same cycle while full is legal; occupancy stays DEPTH.
- On resolve_valid with a non-empty queue, pop the head and train its entry:
  - ph==fix_result, gh!=fix_result: decrement, saturating at 0.
  - gh==fix_result, ph!=fix_result: increment, saturating at 2^CTR_BITS-1.
  - both correct or both wrong: no change.
  - Stored prediction==fix_result: hit+1, else miss+1. Both saturate at all-ones; no wrap.
- resolve_valid on an empty queue: no table or statistics change; resolve_err set until reset.
- flush: a same-cycle resolve is applied to the head first. The queue then empties (inflight=0) with no training of the remaining entries. No push that cycle.
- No bypass: a prediction in the same cycle as a training write to the same index uses the pre-write value.

## Timing
- Reset values: pred_ready=0, inflight=0, hit=0, miss=0, resolve_err=0, FSM=INIT with init pointer 0. prediction, nex_PC and choice_gh follow the pshare inputs.
- INIT lasts 2^IDX_BITS cycles after reset deasserts; pred_ready first rises at cycle 2^IDX_BITS.
- Prediction latency is 0 cycles (combinational).
- Table, queue, statistics and resolve_err update on the clock edge ending the cycle and are visible the next cycle.
- Resolution is strictly in order. A branch accepted in cycle t may resolve at t+1 or later.
- Reset asserted mid-operation immediately clears the queue, statistics and resolve_err, and restarts INIT. Table contents are undefined until the new INIT completes.

## Test plan
(IDX_BITS=4, DEPTH=4, CTR_BITS=2.)
- Init: release reset -> pred_ready=0 for 16 cycles, then 1. Every entry reads 01, so every first prediction takes the pshare path.
- Training: PC=0x40, ph=1, gh=0, fix_result=0, two resolves -> entry 0 goes 01→10→11. Next predict with ph=1/gh=0 gives prediction=0, nex_PC=gh_PC, choice_gh=1. A third such resolve leaves the entry at 11.
- Delayed and full: accept 4 predictions to distinct PCs -> inflight=4, pred_ready=0. With resolve_valid and predict_valid both high, a push is accepted and inflight stays 4. Each pop trains its own stored index. hit/miss equal the counts of stored prediction matching fix_result.
- Flush with resolve: inflight=3, flush=1 and resolve_valid=1 in the same cycle -> only the head trains, inflight=0, and hit+miss rises by 1.
- Empty resolve: resolve_valid with inflight=0 -> resolve_err=1, hit, miss and table unchanged. resolve_err stays set until reset.
- Saturation and reset: with STAT_BITS=4, 20 correct resolves -> hit=15. Assert reset mid-stream -> hit=0, inflight=0, and INIT restarts.

Source files
------------

// File: rtl/tournament_chooser.sv
`default_nettype none
// ============================================================================
// Module   : tournament_chooser
// Brief    : Per-PC pshare/gshare chooser with in-order training queue,
//            table auto-init, flush and saturating hit/miss statistics.
// Revision : 1.0
// ============================================================================
module tournament_chooser #(
    parameter int N         = 32,
    parameter int IDX_BITS  = 10,
    parameter int CTR_BITS  = 2,
    parameter int DEPTH     = 4,
    parameter int STAT_BITS = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   predict_valid,
    output logic                   pred_ready,
    input  logic [N-1:0]           PC,
    input  logic                   prediction_ph,
    input  logic                   prediction_gh,
    input  logic [N-1:0]           ph_PC,
    input  logic [N-1:0]           gh_PC,
    output logic                   prediction,
    output logic [N-1:0]           nex_PC,
    output logic                   choice_gh,
    input  logic                   resolve_valid,
    input  logic                   fix_result,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] inflight,
    output logic [STAT_BITS-1:0]   hit,
    output logic [STAT_BITS-1:0]   miss,
    output logic                   resolve_err
);
    localparam int                     ENTRIES  = 2**IDX_BITS;
    localparam int                     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                     CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]       FULL     = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [IDX_BITS-1:0]    IDX_LAST = '1;
    localparam logic [CTR_BITS-1:0]    CTR_INIT = CTR_BITS'((2**(CTR_BITS-1)) - 1);
    localparam logic [CTR_BITS-1:0]    CTR_MAX  = '1;
    localparam logic [STAT_BITS-1:0]   STAT_MAX = '1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDX_BITS-1:0] idx;
        logic                ph;
        logic                gh;
        logic                pred;
    } entry_t;

    state_t                state_q,    state_d;
    logic [IDX_BITS-1:0]   init_ptr_q, init_ptr_d;
    logic [PTR_W-1:0]      head_q,     head_d;
    logic [PTR_W-1:0]      tail_q,     tail_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [STAT_BITS-1:0]  hit_q,      hit_d;
    logic [STAT_BITS-1:0]  miss_q,     miss_d;
    logic                  err_q,      err_d;

    logic [CTR_BITS-1:0]   tbl_q [ENTRIES];
    entry_t                fifo_q [DEPTH];

    logic [IDX_BITS-1:0]   pred_idx;
    logic [CTR_BITS-1:0]   pred_ctr;
    logic                  accept;
    logic                  pop;
    entry_t                head_e;
    logic [CTR_BITS-1:0]   train_ctr;
    logic                  ph_ok;
    logic                  gh_ok;
    logic                  tbl_we;
    logic [IDX_BITS-1:0]   tbl_widx;
    logic [CTR_BITS-1:0]   tbl_wdata;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^{PC[N-1:IDX_BITS+2], PC[1:0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Prediction path reads the table before any same-cycle training write.
    always_comb begin
        pred_idx   = PC[IDX_BITS+1:2];
        pred_ctr   = tbl_q[pred_idx];
        choice_gh  = (state_q == ST_RUN) && pred_ctr[CTR_BITS-1];
        prediction = choice_gh ? prediction_gh : prediction_ph;
        nex_PC     = choice_gh ? gh_PC : ph_PC;
        pred_ready = (state_q == ST_RUN) && !flush && ((cnt_q != FULL) || resolve_valid);
        accept     = predict_valid && pred_ready;
        pop        = resolve_valid && (cnt_q != '0);
        head_e     = fifo_q[head_q];
        train_ctr  = tbl_q[head_e.idx];
        ph_ok      = (head_e.ph == fix_result);
        gh_ok      = (head_e.gh == fix_result);
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q + CNT_W'(accept) - CNT_W'(pop);
        hit_d      = hit_q;
        miss_d     = miss_q;
        err_d      = err_q;
        tbl_we     = 1'b0;
        tbl_widx   = init_ptr_q;
        tbl_wdata  = CTR_INIT;

        if (state_q == ST_INIT) begin
            tbl_we     = 1'b1;
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == IDX_LAST) begin
                state_d = ST_RUN;
            end
        end else if (pop) begin
            tbl_widx = head_e.idx;
            if (ph_ok && !gh_ok && (train_ctr != '0)) begin
                tbl_we    = 1'b1;
                tbl_wdata = train_ctr - 1'b1;
            end else if (gh_ok && !ph_ok && (train_ctr != CTR_MAX)) begin
                tbl_we    = 1'b1;
                tbl_wdata = train_ctr + 1'b1;
            end
        end

        if (pop) begin
            head_d = ptr_inc(head_q);
            if (head_e.pred == fix_result) begin
                if (hit_q != STAT_MAX) hit_d = hit_q + 1'b1;
            end else begin
                if (miss_q != STAT_MAX) miss_d = miss_q + 1'b1;
            end
        end else if (resolve_valid) begin
            err_d = 1'b1;
        end

        if (accept) begin
            tail_d = ptr_inc(tail_q);
        end

        // Head resolve above still counts; everything behind it is dropped.
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (tbl_we) begin
            tbl_q[tbl_widx] <= tbl_wdata;
        end
        if (accept) begin
            fifo_q[tail_q] <= '{idx: pred_idx, ph: prediction_ph,
                                gh: prediction_gh, pred: prediction};
        end
    end

    assign inflight    = cnt_q;
    assign hit         = hit_q;
    assign miss        = miss_q;
    assign resolve_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tournament_chooser.sv
`default_nettype none
// ============================================================================
// Module   : tb_tournament_chooser
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            random traffic against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_tournament_chooser;
    localparam int N         = 32;
    localparam int IDX_BITS  = 4;
    localparam int CTR_BITS  = 2;
    localparam int DEPTH     = 4;
    localparam int STAT_BITS = 4;
    localparam int ENTRIES   = 1 << IDX_BITS;
    localparam int STAT_MAX  = (1 << STAT_BITS) - 1;
    localparam int CTR_MAX   = (1 << CTR_BITS) - 1;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  predict_valid = 1'b0;
    logic                  pred_ready;
    logic [N-1:0]          PC = '0;
    logic                  prediction_ph = 1'b0;
    logic                  prediction_gh = 1'b0;
    logic [N-1:0]          ph_PC = '0;
    logic [N-1:0]          gh_PC = '0;
    logic                  prediction;
    logic [N-1:0]          nex_PC;
    logic                  choice_gh;
    logic                  resolve_valid = 1'b0;
    logic                  fix_result = 1'b0;
    logic                  flush = 1'b0;
    logic [2:0]            inflight;
    logic [STAT_BITS-1:0]  hit;
    logic [STAT_BITS-1:0]  miss;
    logic                  resolve_err;

    tournament_chooser #(
        .N(N), .IDX_BITS(IDX_BITS), .CTR_BITS(CTR_BITS),
        .DEPTH(DEPTH), .STAT_BITS(STAT_BITS)
    ) dut (
        .clock(clock), .reset(reset),
        .predict_valid(predict_valid), .pred_ready(pred_ready),
        .PC(PC), .prediction_ph(prediction_ph), .prediction_gh(prediction_gh),
        .ph_PC(ph_PC), .gh_PC(gh_PC),
        .prediction(prediction), .nex_PC(nex_PC), .choice_gh(choice_gh),
        .resolve_valid(resolve_valid), .fix_result(fix_result), .flush(flush),
        .inflight(inflight), .hit(hit), .miss(miss), .resolve_err(resolve_err)
    );

    always #5 clock = ~clock;

    // Reference model state
    typedef struct {
        int idx;
        bit ph;
        bit gh;
        bit pred;
    } qent_t;

    int    m_tbl [ENTRIES];
    int    m_init_cnt;
    int    m_hit;
    int    m_miss;
    bit    m_err;
    bit    m_last_pred;
    qent_t m_q [$];

    int checks = 0;
    int errors = 0;

    // Outputs sampled during the most recent cycle
    logic [31:0] s_pred, s_choice, s_npc, s_infl, s_hit, s_miss, s_err, s_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit pv, input logic [31:0] pc, input bit ph, input bit gh,
                       input logic [31:0] phpc, input logic [31:0] ghpc,
                       input bit rv, input bit fix, input bit fl);
        bit          run, gs, e_pred, e_ready;
        logic [31:0] e_npc;
        int          idx;
        qent_t       e;
        @(negedge clock);
        predict_valid = pv;   PC = pc;
        prediction_ph = ph;   prediction_gh = gh;
        ph_PC = phpc;         gh_PC = ghpc;
        resolve_valid = rv;   fix_result = fix;   flush = fl;
        #1;
        run     = (m_init_cnt >= ENTRIES);
        idx     = int'((pc >> 2) % ENTRIES);
        gs      = run && (m_tbl[idx] >= (1 << (CTR_BITS - 1)));
        e_pred  = gs ? gh : ph;
        e_npc   = gs ? ghpc : phpc;
        e_ready = run && !fl && ((m_q.size() < DEPTH) || rv);
        m_last_pred = e_pred;
        s_pred = 32'(prediction); s_choice = 32'(choice_gh); s_npc = nex_PC;
        s_infl = 32'(inflight);   s_hit = 32'(hit);          s_miss = 32'(miss);
        s_err  = 32'(resolve_err); s_ready = 32'(pred_ready);
        check("choice_gh",   s_choice, 32'(gs));
        check("prediction",  s_pred,   32'(e_pred));
        check("nex_PC",      s_npc,    e_npc);
        check("pred_ready",  s_ready,  32'(e_ready));
        check("inflight",    s_infl,   32'(m_q.size()));
        check("hit",         s_hit,    32'(m_hit));
        check("miss",        s_miss,   32'(m_miss));
        check("resolve_err", s_err,    32'(m_err));
        @(posedge clock);
        if (!run) begin
            m_init_cnt++;
            if (m_init_cnt == ENTRIES)
                for (int i = 0; i < ENTRIES; i++) m_tbl[i] = (1 << (CTR_BITS - 1)) - 1;
        end
        if (rv) begin
            if (m_q.size() > 0) begin
                e = m_q.pop_front();
                if (e.ph == fix && e.gh != fix) begin
                    if (m_tbl[e.idx] > 0) m_tbl[e.idx]--;
                end else if (e.gh == fix && e.ph != fix) begin
                    if (m_tbl[e.idx] < CTR_MAX) m_tbl[e.idx]++;
                end
                if (e.pred == fix) begin
                    if (m_hit < STAT_MAX) m_hit++;
                end else begin
                    if (m_miss < STAT_MAX) m_miss++;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        if (fl) m_q.delete();
        else if (pv && e_ready) m_q.push_back('{idx, ph, gh, e_pred});
    endtask

    task automatic idle();
        cyc(0, 32'h0, 1'b0, 1'b0, 32'h1000, 32'h2000, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        predict_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
        prediction_ph = 1'b1; prediction_gh = 1'b0;
        ph_PC = 32'hAAAA_0000; gh_PC = 32'h5555_0000;
        reset = 1'b1;
        #1;
        // Asynchronous: cleared without waiting for a clock edge
        check("rst pred_ready",  32'(pred_ready),  32'd0);
        check("rst inflight",    32'(inflight),    32'd0);
        check("rst hit",         32'(hit),         32'd0);
        check("rst miss",        32'(miss),        32'd0);
        check("rst resolve_err", 32'(resolve_err), 32'd0);
        check("rst choice_gh",   32'(choice_gh),   32'd0);
        check("rst nex_PC",      nex_PC,           32'hAAAA_0000);
        m_init_cnt = 0; m_hit = 0; m_miss = 0; m_err = 1'b0;
        m_q.delete();
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    typedef struct {
        bit          pv;
        logic [31:0] pc;
        bit          ph, gh, rv, fix;
        bit          e_pred, e_choice;
        logic [31:0] e_npc;
        int          e_infl, e_hit, e_miss;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Training of entry 0 from weak pshare up to saturated gshare
        vecs[0] = '{1, 32'h40, 1, 0, 0, 0, 1, 0, 32'h1000, 0, 0, 0};
        vecs[1] = '{0, 32'h40, 1, 0, 1, 0, 1, 0, 32'h1000, 1, 0, 0};
        vecs[2] = '{1, 32'h40, 1, 0, 0, 0, 0, 1, 32'h2000, 0, 0, 1};
        vecs[3] = '{0, 32'h40, 1, 0, 1, 0, 0, 1, 32'h2000, 1, 0, 1};
        vecs[4] = '{1, 32'h40, 1, 0, 0, 0, 0, 1, 32'h2000, 0, 1, 1};
        vecs[5] = '{0, 32'h40, 1, 0, 1, 0, 0, 1, 32'h2000, 1, 1, 1};
        vecs[6] = '{0, 32'h40, 1, 0, 0, 0, 0, 1, 32'h2000, 0, 2, 1};
        vecs[7] = '{0, 32'h44, 0, 1, 0, 0, 0, 0, 32'h1000, 0, 2, 1};

        do_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            idle();
            check("init pred_ready low", s_ready, 32'd0);
        end
        idle();
        check("init pred_ready high", s_ready, 32'd1);

        for (int i = 0; i < 8; i++) begin
            cyc(vecs[i].pv, vecs[i].pc, vecs[i].ph, vecs[i].gh, 32'h1000, 32'h2000,
                vecs[i].rv, vecs[i].fix, 0);
            check($sformatf("vec%0d prediction", i), s_pred,   32'(vecs[i].e_pred));
            check($sformatf("vec%0d choice_gh", i),  s_choice, 32'(vecs[i].e_choice));
            check($sformatf("vec%0d nex_PC", i),     s_npc,    vecs[i].e_npc);
            check($sformatf("vec%0d inflight", i),   s_infl,   32'(vecs[i].e_infl));
            check($sformatf("vec%0d hit", i),        s_hit,    32'(vecs[i].e_hit));
            check($sformatf("vec%0d miss", i),       s_miss,   32'(vecs[i].e_miss));
        end

        // Fill the queue, stall while full, then push and pop together
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 32'((i + 2) << 2), 1'($urandom), 1'($urandom), 32'h1100, 32'h2200, 0, 0, 0);
        cyc(1, 32'h60, 1, 1, 32'h1100, 32'h2200, 0, 0, 0);
        check("full pred_ready", s_ready, 32'd0);
        check("full inflight",   s_infl,  32'd4);
        cyc(1, 32'h64, 0, 1, 32'h1100, 32'h2200, 1, 1'($urandom), 0);
        check("full push+pop ready", s_ready, 32'd1);
        idle();
        check("full stays 4", s_infl, 32'd4);
        for (int i = 0; i < DEPTH; i++)
            cyc(0, 32'((i + 3) << 2), 1, 0, 32'h1100, 32'h2200, 1, 1'($urandom), 0);
        idle();
        check("drained", s_infl, 32'd0);

        // Flush with same-cycle resolve
        for (int i = 0; i < 3; i++)
            cyc(1, 32'((i + 5) << 2), 1'($urandom), 1'($urandom), 32'h1, 32'h2, 0, 0, 0);
        cyc(1, 32'h80, 1, 0, 32'h1, 32'h2, 1, 1'($urandom), 1);
        idle();
        check("flush inflight", s_infl, 32'd0);
        check("flush hit+miss", s_hit + s_miss, 32'(m_hit + m_miss));

        // Resolve with an empty queue
        cyc(0, 32'h0, 0, 0, 32'h1, 32'h2, 1, 1, 0);
        idle();
        check("empty resolve_err", s_err, 32'd1);
        idle();
        check("resolve_err sticky", s_err, 32'd1);

        // Hit counter saturation
        for (int i = 0; i < 20; i++) begin
            cyc(1, 32'h90, 1'($urandom), 1'($urandom), 32'h3, 32'h4, 0, 0, 0);
            cyc(0, 32'h90, 0, 0, 32'h3, 32'h4, 1, m_last_pred, 0);
        end
        idle();
        check("hit saturated", s_hit, 32'd15);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom,
                ($urandom_range(0, 2) == 0), 1'($urandom), ($urandom_range(0, 15) == 0));

        // Reset mid-stream and re-run INIT
        cyc(1, 32'h10, 1, 1, 32'h1, 32'h2, 0, 0, 0);
        do_reset();
        for (int i = 0; i < ENTRIES; i++) idle();
        idle();
        check("reinit pred_ready", s_ready, 32'd1);
        check("reinit hit",        s_hit,   32'd0);
        for (int i = 0; i < 40; i++)
            cyc(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom,
                ($urandom_range(0, 2) == 0), 1'($urandom), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
